// File: rtl/clb_conf_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : clb_conf_loader_if
// Purpose  : Groups the configuration-word stream and the register-file
//            configuration / multiport-enable port used by clb_conf_loader.
// Ports    : in_valid/in_data/in_ready   - configuration word stream
//            clb_conf5                    - readback of CONF_BASE+4
//            write_enable_conf/addr/data  - configuration write port
//            write_enable_CLB             - multiport write enable
// Modports : slave  - the loader (stream sink, register-file driver)
//            master - the environment (stream source, register file)
// Revision : 1.0  initial release
// ============================================================================
interface clb_conf_loader_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] clb_conf5;
  logic             write_enable_conf;
  logic [5:0]       write_addr_conf;
  logic [WIDTH-1:0] write_data_conf;
  logic             write_enable_CLB;

  modport slave (
    input  in_valid, in_data, clb_conf5,
    output in_ready, write_enable_conf, write_addr_conf, write_data_conf,
           write_enable_CLB
  );

  modport master (
    output in_valid, in_data, clb_conf5,
    input  in_ready, write_enable_conf, write_addr_conf, write_data_conf,
           write_enable_CLB
  );
endinterface
`default_nettype wire

// File: rtl/clb_conf_loader.sv
`default_nettype none
// ============================================================================
// Module   : clb_conf_loader
// Purpose  : Loads a burst of 1..CONF_MAX configuration words into the CLB
//            configuration window of the register file, reads back the run
//            length from CONF_BASE+4 and holds the multiport write enable
//            for that many cycles, then pulses done.
// Ports    : clk        - system clock
//            rst_n      - synchronous active-low reset
//            start      - request a sequence (sampled in IDLE only)
//            cfg_count  - words in the burst, legal 1..CONF_MAX
//            abort      - synchronous abort of a running sequence
//            bus        - stream + register-file port (slave modport)
//            busy       - sequence in progress
//            done       - one-cycle completion pulse
//            cfg_error  - one-cycle pulse on start with illegal cfg_count
// Revision : 1.0  initial release
// ============================================================================
module clb_conf_loader #(
  parameter int WIDTH     = 32,
  parameter int CONF_BASE = 32,
  parameter int CONF_MAX  = 5
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          start,
  input  wire logic [2:0]    cfg_count,
  input  wire logic          abort,
  clb_conf_loader_if.slave   bus,
  output logic               busy,
  output logic               done,
  output logic               cfg_error
);

  localparam logic [5:0] c_conf_base = 6'(CONF_BASE);
  localparam logic [2:0] c_conf_max  = 3'(CONF_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_ARM    = 3'd3,
    S_RUN    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           state_q;
  logic [2:0]       cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       run_cnt_q;
  logic             we_conf_q;
  logic [5:0]       addr_q;
  logic [WIDTH-1:0] data_q;
  logic             we_clb_q;
  logic             done_q;
  logic             cfg_error_q;

  logic             w_cfg_legal;
  logic             w_last_word;

  // Only the low byte of the readback carries the run length.
  logic [WIDTH-9:0] w_unused_conf5;
  assign w_unused_conf5 = bus.clb_conf5[WIDTH-1:8];

  assign w_cfg_legal = (cfg_count != 3'd0) && (cfg_count <= c_conf_max);
  assign w_last_word = (idx_q == (cnt_q - 3'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      idx_q       <= 3'd0;
      run_cnt_q   <= 8'd0;
      we_conf_q   <= 1'b0;
      addr_q      <= 6'd0;
      data_q      <= '0;
      we_clb_q    <= 1'b0;
      done_q      <= 1'b0;
      cfg_error_q <= 1'b0;
    end else begin
      // Pulse outputs default low; each asserting branch raises them for
      // exactly one cycle.
      we_conf_q   <= 1'b0;
      done_q      <= 1'b0;
      cfg_error_q <= 1'b0;

      if (abort && (state_q != S_IDLE)) begin
        // Abort wins over any transfer in this cycle: the word is dropped.
        state_q   <= S_IDLE;
        idx_q     <= 3'd0;
        run_cnt_q <= 8'd0;
        addr_q    <= 6'd0;
        data_q    <= '0;
        we_clb_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              if (w_cfg_legal) begin
                cnt_q   <= cfg_count;
                idx_q   <= 3'd0;
                state_q <= S_LOAD;
              end else begin
                cfg_error_q <= 1'b1;
              end
            end
          end

          S_LOAD: begin
            if (bus.in_valid) begin
              we_conf_q <= 1'b1;
              addr_q    <= c_conf_base + {3'b000, idx_q};
              data_q    <= bus.in_data;
              if (w_last_word) begin
                state_q <= S_SETTLE;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end
          end

          // The last word's strobe is visible during this cycle, so the
          // register file commits it before ARM samples the readback.
          S_SETTLE: state_q <= S_ARM;

          S_ARM: begin
            run_cnt_q <= bus.clb_conf5[7:0];
            if (bus.clb_conf5[7:0] == 8'd0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              we_clb_q <= 1'b1;
              state_q  <= S_RUN;
            end
          end

          S_RUN: begin
            run_cnt_q <= run_cnt_q - 8'd1;
            if (run_cnt_q == 8'd1) begin
              we_clb_q <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end
          end

          S_DONE: state_q <= S_IDLE;

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready          = (state_q == S_LOAD);
  assign bus.write_enable_conf = we_conf_q;
  assign bus.write_addr_conf   = addr_q;
  assign bus.write_data_conf   = data_q;
  assign bus.write_enable_CLB  = we_clb_q;
  assign busy                  = (state_q != S_IDLE);
  assign done                  = done_q;
  assign cfg_error             = cfg_error_q;

endmodule
`default_nettype wire

// File: doc/clb_conf_loader.md
Name: clb_conf_loader

Overview:
- Upstream sequencer for the multiport register file's CLB configuration window (addresses 32..36).
- Accepts a burst of 1..5 configuration words over a valid/ready stream and writes them through the file's configuration write port.
- Then reads back the run length from configuration register 36 and holds the file's multiport write enable for exactly that many cycles.
- Signals completion with a one-cycle done pulse; supports synchronous abort.

Parameters:
- WIDTH, 32, data width of configuration words and of the register file.
- CONF_BASE, 32, register-file address of the first configuration register.
- CONF_MAX, 5, maximum number of configuration words per burst.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a load/run sequence; sampled only in IDLE.
- cfg_count  input  3  number of words to load; legal range 1..CONF_MAX; sampled with start.
- abort  input  1  synchronous abort; takes effect at the next edge.
- in_valid  input  1  configuration word present on in_data.
- in_data  input  WIDTH  configuration word.
- in_ready  output  1  loader can accept a word this cycle.
- clb_conf5  input  WIDTH  readback of register CONF_BASE+4; bits [7:0] give the run length.
- write_enable_conf  output  1  configuration write strobe to the register file.
- write_addr_conf  output  6  configuration write address.
- write_data_conf  output  WIDTH  configuration write data.
- write_enable_CLB  output  1  multiport write enable to the register file.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse at the end of a completed sequence.
- cfg_error  output  1  one-cycle pulse when start arrives with an illegal cfg_count.

Behaviour:
- Reset: rst_n low at a rising edge forces state IDLE and clears the index and run counter. All outputs are 0 after that edge: in_ready, write_enable_conf, write_addr_conf, write_data_conf, write_enable_CLB, busy, done, cfg_error. Reset mid-sequence does the same; no further writes are issued.
- States: IDLE, LOAD, SETTLE, ARM, RUN, DONE.
- IDLE:
  - start with cfg_count in 1..CONF_MAX: latch cfg_count, set idx=0, go to LOAD.
  - start with cfg_count 0 or greater than CONF_MAX: cfg_error=1 for the next cycle, stay in IDLE.
  - start outside IDLE is ignored.
- LOAD:
  - in_ready=1 (combinational from state).
  - A transfer happens on in_valid&in_ready.
  - On each transfer, the next cycle has write_enable_conf=1, write_addr_conf=CONF_BASE+idx, write_data_conf=in_data. Output latency is exactly 1 cycle.
  - idx increments on each transfer.
  - Transfer of word number cfg_count-1 moves the state to SETTLE.
  - in_valid low leaves the state unchanged with no write strobe. There is no timeout.
- SETTLE: one cycle. The last word's write_enable_conf is high during it, so the register file commits at the end of SETTLE. Go to ARM.
- ARM: one cycle. Sample clb_conf5[7:0] into run_cnt.
  - If the value is 0, go to DONE; write_enable_CLB never asserts.
  - Otherwise go to RUN.
- RUN:
  - write_enable_CLB=1.
  - run_cnt decrements each cycle; leave for DONE after the cycle in which run_cnt==1.
  - write_enable_CLB is therefore high for exactly N consecutive cycles.
- DONE: done=1 for one cycle, then go to IDLE.
- write_enable_conf is low in every cycle not immediately following a LOAD transfer. write_addr_conf and write_data_conf hold their last values when the strobe is low.
- abort=1 in any non-IDLE state: next state is IDLE and registered outputs clear at that edge. done does not pulse. Strobes already asserted in the current cycle complete. abort in IDLE has no effect.
- Simultaneous events:
  - rst_n has priority over abort.
  - abort has priority over a transfer in the same cycle; that word is dropped with no write.
- Address arithmetic: CONF_BASE+idx is 6-bit, and idx never exceeds CONF_MAX-1. A partial burst (cfg_count<5) leaves the higher configuration registers untouched.
- busy is 1 from the cycle after an accepted start through the DONE cycle inclusive.

Test Plan:
- Full burst: start with cfg_count=5; words 0xA0000001..0xA0000005 with in_valid held high; clb_conf5 model returns 0x00000003 → write strobes at addresses 32..36 on 5 consecutive cycles with matching data. write_enable_CLB high for exactly 3 cycles, starting 2 cycles after the last conf strobe. done pulses once; busy then drops.
- Throttled input: cfg_count=2, in_valid toggled 1,0,0,1 → exactly 2 strobes (addresses 32 and 33), each 1 cycle after its accepted beat. No strobe during the idle beats.
- Zero run length: clb_conf5[7:0]=0 → write_enable_CLB never asserts; done pulses in the cycle after ARM.
- Illegal count: start with cfg_count=0, then with cfg_count=6 → cfg_error pulses each time, busy stays 0, in_ready stays 0, no writes.
- Abort in RUN: run length 10, abort asserted on the 4th RUN cycle → write_enable_CLB drops at the next edge after 4 cycles high. done does not pulse; the state returns to IDLE and a new start is accepted.
- Reset mid-LOAD: rst_n low after 2 of 4 words → all outputs 0 at the next edge, addresses 34 and 35 not written, in_ready stays 0 until a new start.
